// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state encoding and line-buffer index widths
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOST  = 2'd2
  } arb_state_t;

  localparam int BANK_W = 1;
  localparam int WORD_W = 10;
  localparam int LINE_W = 12;
  localparam int LB_AW  = BANK_W + WORD_W;

  // Line-buffer write index: bank selects the odd/even line, word is the pixel column
  function automatic logic [LB_AW-1:0] lb_index(input logic [BANK_W-1:0] bank,
                                                input logic [WORD_W-1:0] word);
    return {bank, word};
  endfunction

endpackage

// File: rtl/vga_fetch_addr.sv
// rtl/vga_fetch_addr.sv - registered line*H_ACTIVE+word address generator
module vga_fetch_addr
  import vga_pkg::*;
#(
  parameter int          AW       = 20,
  parameter int          H_ACTIVE = 640,
  parameter int unsigned BASE     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINE_W-1:0] line,
  input  logic [WORD_W-1:0] word,
  output logic [AW-1:0]     addr
);

  // Fed with next-cycle counter values, so addr lines up with the live counters
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else begin
      addr <= AW'(BASE) + AW'(line) * AW'(H_ACTIVE) + AW'(word);
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - display line prefetch and host access arbiter
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          V_TOTAL  = 525,
  parameter int          AW       = 20,
  parameter int          DW       = 16,
  parameter int unsigned BASE     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      hdata,
  input  logic [11:0]      vdata,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_ack,
  output logic [DW-1:0]    host_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic             mem_ack,
  input  logic [DW-1:0]    mem_rdata,
  output logic             lb_we,
  output logic [LB_AW-1:0] lb_addr,
  output logic [DW-1:0]    lb_wdata,
  output logic             fetch_busy,
  output logic             underrun
);

  arb_state_t        state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d, pend_line_q, pend_line_d, trig_line;
  logic [WORD_W-1:0] word_q, word_d;
  logic              pend_q, pend_d, underrun_q;
  logic              trig, restart, fetch_sel, host_sel;
  logic [AW-1:0]     fetch_addr;

  // A pending or fresh trigger while fetching means the current line is abandoned
  assign restart   = pend_q || trig;
  assign fetch_sel = (state_q == ST_FETCH);
  // Zero-wait host accesses complete straight from IDLE; a stalled one parks in HOST
  assign host_sel  = (state_q == ST_HOST) ||
                     ((state_q == ST_IDLE) && host_req && !trig && !pend_q);

  // Line-start triggers: next visible line, or line 0 during the last blanking line
  always_comb begin
    trig      = (hdata == 12'd0) &&
                ((vdata < 12'(V_ACTIVE - 1)) || (vdata == 12'(V_TOTAL - 1)));
    trig_line = (vdata == 12'(V_TOTAL - 1)) ? '0 : vdata + 12'd1;
  end

  // Next state, fetch counters and pending-trigger bookkeeping
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    word_d      = word_q;
    pend_d      = pend_q;
    pend_line_d = pend_line_q;
    if (trig) begin
      pend_d      = 1'b1;
      pend_line_d = trig_line;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (trig || pend_q) begin
          state_d = ST_FETCH;
          line_d  = trig ? trig_line : pend_line_q;
          word_d  = '0;
          pend_d  = 1'b0;
        end else if (host_req && !mem_ack) begin
          state_d = ST_HOST;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          if (restart) begin
            line_d = trig ? trig_line : pend_line_q;
            word_d = '0;
            pend_d = 1'b0;
          end else if (word_q == WORD_W'(H_ACTIVE - 1)) begin
            state_d = ST_IDLE;
            word_d  = '0;
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end
      end
      ST_HOST: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; underrun fires the cycle after a trigger lands mid-fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      word_q      <= '0;
      pend_q      <= 1'b0;
      pend_line_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      word_q      <= word_d;
      pend_q      <= pend_d;
      pend_line_q <= pend_line_d;
      underrun_q  <= trig && fetch_sel;
    end
  end

  vga_fetch_addr #(
    .AW       (AW),
    .H_ACTIVE (H_ACTIVE),
    .BASE     (BASE)
  ) u_addr (
    .clk  (clk),
    .rst  (rst),
    .line (line_d),
    .word (word_d),
    .addr (fetch_addr)
  );

  // Memory and line-buffer port steering; everything forced low while in reset
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    host_ack   = 1'b0;
    host_rdata = '0;
    lb_we      = 1'b0;
    lb_addr    = '0;
    lb_wdata   = '0;
    fetch_busy = 1'b0;
    underrun   = 1'b0;
    if (!rst) begin
      fetch_busy = fetch_sel || pend_q;
      underrun   = underrun_q;
      lb_addr    = lb_index(line_q[0], word_q);
      if (fetch_sel) begin
        mem_req  = 1'b1;
        mem_addr = fetch_addr;
        lb_we    = mem_ack && !restart;
        lb_wdata = mem_rdata;
      end else if (host_sel) begin
        mem_req    = 1'b1;
        mem_we     = host_we;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        host_ack   = mem_ack;
        host_rdata = mem_ack ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - directed self-checking bench for vga_mem_arbiter
`timescale 1ns/1ps
module tb_vga_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   hdata, vdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          lb_we;
  logic [10:0]   lb_addr;
  logic [DW-1:0] lb_wdata;
  logic          fetch_busy, underrun;
  logic          ack_en;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  assign mem_ack   = mem_req & ack_en;
  assign mem_rdata = mem_word(mem_addr);

  vga_mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .hdata      (hdata),
    .vdata      (vdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .lb_wdata   (lb_wdata),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hdata = 12'd0; vdata = 12'd0; ack_en = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00ABC; host_wdata = 16'h1234;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, host_ack, lb_we, underrun, fetch_busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req/we/hack/lbwe/underrun/busy=%b want 000000",
               {mem_req, mem_we, host_ack, lb_we, underrun, fetch_busy});
    end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0 || lb_addr !== '0 || lb_wdata !== '0 || host_rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data: maddr=%h mwd=%h lba=%h lbwd=%h hrd=%h want all 0",
               mem_addr, mem_wdata, lb_addr, lb_wdata, host_rdata);
    end
    tick(); rst = 1'b0; host_req = 1'b0; hdata = 12'd1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: mem_req=%b fetch_busy=%b want 0/0", mem_req, fetch_busy);
    end
  endtask

  task automatic test_line_fetch(input string name, input int v, input int line);
    logic [AW-1:0] ea;
    logic [10:0]   el;
    tick(); hdata = 12'd0; vdata = 12'(v);
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_trigger: mem_req=%b fetch_busy=%b want 0/0", name, mem_req, fetch_busy);
    end
    for (int w = 0; w < 640; w++) begin
      tick(); hdata = 12'd1;
      @(negedge clk);
      ea = AW'(line * 640 + w);
      el = 11'((line % 2) * 1024 + w);
      vectors++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea || lb_we !== 1'b1 ||
          lb_addr !== el || lb_wdata !== mem_word(ea) || fetch_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_word%0d: req=%b we=%b addr=%h lbwe=%b lba=%h lbwd=%h busy=%b want 1 0 %h 1 %h %h 1",
                 name, w, mem_req, mem_we, mem_addr, lb_we, lb_addr, lb_wdata, fetch_busy,
                 ea, el, mem_word(ea));
      end
    end
    tick();
    @(negedge clk);
    vectors++;
    if (fetch_busy !== 1'b0 || mem_req !== 1'b0 || lb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: busy=%b req=%b lbwe=%b want 0/0/0", name, fetch_busy, mem_req, lb_we);
    end
  endtask

  task automatic test_host_vs_fetch();
    int cycles = 0;
    int writes = 0;
    bit got = 0;
    tick(); host_req = 1'b1; host_we = 1'b0; host_addr = 20'h12345; hdata = 12'd0; vdata = 12'd10;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || host_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_wins: mem_req=%b host_ack=%b want 0/0", mem_req, host_ack);
    end
    while (!got && cycles < 2000) begin
      tick(); hdata = 12'd1;
      @(negedge clk);
      cycles++;
      if (lb_we === 1'b1) writes++;
      if (host_ack === 1'b1) got = 1;
    end
    vectors++;
    if (cycles != 641 || writes != 640) begin
      miscompares++;
      $display("FAIL host_after_fetch: ack_cycle=%0d lb_writes=%0d want 641/640", cycles, writes);
    end
    vectors++;
    if (host_rdata !== mem_word(20'h12345) || mem_addr !== 20'h12345 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL host_read_data: rdata=%h addr=%h we=%b want %h 12345 0",
               host_rdata, mem_addr, mem_we, mem_word(20'h12345));
    end
    tick(); host_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (host_ack !== 1'b0 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL host_release: ack=%b req=%b want 0/0", host_ack, mem_req);
    end
  endtask

  task automatic test_underrun();
    logic [AW-1:0] stall_addr;
    logic [AW-1:0] ea;
    int bad = 0;
    stall_addr = AW'(21 * 640 + 10);
    tick(); hdata = 12'd0; vdata = 12'd20;
    @(negedge clk);
    for (int w = 0; w < 10; w++) begin
      tick(); hdata = 12'd1;
      @(negedge clk);
    end
    for (int i = 0; i < 200; i++) begin
      tick(); ack_en = 1'b0;
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_addr !== stall_addr || lb_we !== 1'b0 || underrun !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL stall_hold: %0d bad cycles, last addr=%h want 0 bad, addr %h", bad, mem_addr, stall_addr);
    end
    tick(); hdata = 12'd0; vdata = 12'd21;
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_early: underrun=%b want 0", underrun);
    end
    tick(); hdata = 12'd1;
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b1 || fetch_busy !== 1'b1 || mem_addr !== stall_addr || mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun_pulse: underrun=%b busy=%b addr=%h req=%b want 1 1 %h 1",
               underrun, fetch_busy, mem_addr, mem_req, stall_addr);
    end
    tick(); ack_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (underrun !== 1'b0 || lb_we !== 1'b0 || mem_ack !== 1'b1 || mem_addr !== stall_addr) begin
      miscompares++;
      $display("FAIL abandon_ack: underrun=%b lbwe=%b ack=%b addr=%h want 0 0 1 %h",
               underrun, lb_we, mem_ack, mem_addr, stall_addr);
    end
    bad = 0;
    for (int w = 0; w < 640; w++) begin
      tick();
      @(negedge clk);
      ea = AW'(22 * 640 + w);
      if (lb_we !== 1'b1 || mem_addr !== ea || lb_addr !== 11'(w) || lb_wdata !== mem_word(ea)) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL restart_line22: %0d bad words want 0", bad);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (fetch_busy !== 1'b0 || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_done: busy=%b underrun=%b want 0/0", fetch_busy, underrun);
    end
  endtask

  task automatic test_reset_midhandshake();
    tick(); hdata = 12'd0; vdata = 12'd100;
    @(negedge clk);
    for (int w = 0; w < 5; w++) begin
      tick(); hdata = 12'd1;
      @(negedge clk);
    end
    tick(); ack_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== AW'(101 * 640 + 5)) begin
      miscompares++;
      $display("FAIL pre_reset_stall: req=%b addr=%h want 1 %h", mem_req, mem_addr, AW'(101 * 640 + 5));
    end
    tick(); rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_req, lb_we, host_ack, underrun, fetch_busy} !== 5'b0 || mem_addr !== '0 || lb_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_drop: req/lbwe/hack/ur/busy=%b addr=%h lba=%h want 0 0 0",
               {mem_req, lb_we, host_ack, underrun, fetch_busy}, mem_addr, lb_addr);
    end
    tick(); rst = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || lb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: req=%b busy=%b lbwe=%b want 0/0/0", mem_req, fetch_busy, lb_we);
    end
    test_line_fetch("post_reset", 200, 201);
  endtask

  task automatic test_host_pending();
    int cycles = 0;
    int writes = 0;
    bit got = 0;
    logic [AW-1:0] first_addr = '1;
    logic [10:0]   first_lb = '1;
    tick(); ack_en = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00777;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b1 || host_ack !== 1'b0 || mem_addr !== 20'h00777) begin
      miscompares++;
      $display("FAIL host_issue: req=%b ack=%b addr=%h want 1 0 00777", mem_req, host_ack, mem_addr);
    end
    tick(); @(negedge clk);
    tick(); hdata = 12'd0; vdata = 12'd30;
    @(negedge clk);
    vectors++;
    if (fetch_busy !== 1'b0 || mem_addr !== 20'h00777) begin
      miscompares++;
      $display("FAIL host_trigger_cycle: busy=%b addr=%h want 0 00777", fetch_busy, mem_addr);
    end
    tick(); hdata = 12'd1;
    @(negedge clk);
    vectors++;
    if (fetch_busy !== 1'b1 || mem_addr !== 20'h00777 || host_ack !== 1'b0 || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL pending_latched: busy=%b addr=%h ack=%b ur=%b want 1 00777 0 0",
               fetch_busy, mem_addr, host_ack, underrun);
    end
    tick(); ack_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (host_ack !== 1'b1 || host_rdata !== mem_word(20'h00777)) begin
      miscompares++;
      $display("FAIL host_stalled_ack: ack=%b rdata=%h want 1 %h", host_ack, host_rdata, mem_word(20'h00777));
    end
    tick(); host_addr = 20'h00888;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || host_ack !== 1'b0 || fetch_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL host_blocked: req=%b ack=%b busy=%b want 0 0 1", mem_req, host_ack, fetch_busy);
    end
    while (!got && cycles < 1000) begin
      tick();
      @(negedge clk);
      cycles++;
      if (lb_we === 1'b1) begin
        if (writes == 0) begin
          first_addr = mem_addr;
          first_lb = lb_addr;
        end
        writes++;
      end
      if (host_ack === 1'b1) got = 1;
    end
    vectors++;
    if (cycles != 641 || writes != 640) begin
      miscompares++;
      $display("FAIL pending_fetch: ack_cycle=%0d writes=%0d want 641/640", cycles, writes);
    end
    vectors++;
    if (first_addr !== AW'(31 * 640) || first_lb !== 11'h400) begin
      miscompares++;
      $display("FAIL pending_first_word: addr=%h lba=%h want %h 400", first_addr, first_lb, AW'(31 * 640));
    end
    vectors++;
    if (host_rdata !== mem_word(20'h00888)) begin
      miscompares++;
      $display("FAIL host_after_pending: rdata=%h want %h", host_rdata, mem_word(20'h00888));
    end
    tick(); host_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int v = 479; v <= 523; v++) begin
      a = AW'(32'h1000 + v);
      d = DW'(v * 3);
      tick(); hdata = 12'd0; vdata = 12'(v);
      host_req = 1'b1; host_we = v[0]; host_addr = a; host_wdata = d;
      @(negedge clk);
      vectors++;
      if (host_ack !== 1'b1 || mem_req !== 1'b1 || mem_addr !== a || mem_we !== v[0] ||
          fetch_busy !== 1'b0 || lb_we !== 1'b0 ||
          (v[0] ? (mem_wdata !== d) : (host_rdata !== mem_word(a)))) begin
        miscompares++;
        $display("FAIL b2b_v%0d: ack=%b req=%b addr=%h we=%b busy=%b lbwe=%b wd=%h rd=%h want 1 1 %h %b 0 0",
                 v, host_ack, mem_req, mem_addr, mem_we, fetch_busy, lb_we, mem_wdata, host_rdata, a, v[0]);
      end
    end
    tick(); host_req = 1'b0; host_we = 1'b0; hdata = 12'd1;
    @(negedge clk);
    vectors++;
    if (mem_req !== 1'b0 || fetch_busy !== 1'b0 || host_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: req=%b busy=%b ack=%b want 0/0/0", mem_req, fetch_busy, host_ack);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line_fetch("line1", 0, 1);
    test_line_fetch("wrap", 524, 0);
    test_host_vs_fetch();
    test_underrun();
    test_reset_midhandshake();
    test_host_pending();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels (= words fetched) per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter V_TOTAL, default 525, total lines per frame.
REQ-004 Parameter AW, default 20, memory word-address width; DW, default 16, data width.
REQ-005 Parameter BASE, default 0, word address of line 0 pixel 0.
REQ-006 The design SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-007 clk  in  1  pixel clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 hdata  in  12  horizontal counter from timing generator.
REQ-010 vdata  in  12  vertical counter from timing generator.
REQ-011 host_req / host_we  in  1 / 1  host access request, write enable; held until host_ack.
REQ-012 host_addr / host_wdata  in  AW / DW  host address and write data; held with host_req.
REQ-013 host_ack  out  1  one-cycle completion pulse; host_rdata  out  DW  valid with host_ack on reads.
REQ-014 mem_req / mem_we  out  1 / 1  memory request, write enable.
REQ-015 mem_addr / mem_wdata  out  AW / DW  memory address, write data.
REQ-016 mem_ack  in  1  accept/complete, may assert in the first mem_req cycle; mem_rdata  in  DW  valid with mem_ack.
REQ-017 lb_we  out  1,  lb_addr  out  11 ({bank, word[9:0]}),  lb_wdata  out  DW  line-buffer write port.
REQ-018 fetch_busy  out  1  display fetch in progress; underrun  out  1  one-cycle pulse on a missed line deadline.

Function
REQ-019 Trigger: at hdata==0 with vdata<V_ACTIVE-1, fetch line vdata+1; at hdata==0 with vdata==V_TOTAL-1, fetch line 0; no other triggers.
REQ-020 Fetch of line L SHALL read words 0..H_ACTIVE-1 at BASE + L*H_ACTIVE + w, in ascending order, and write each to lb_addr {L[0], w}.
REQ-021 States: IDLE, FETCH, HOST.
REQ-022 IDLE -> FETCH on trigger or pending fetch; else IDLE -> HOST on host_req; fetch wins a simultaneous request.
REQ-023 FETCH SHALL issue one outstanding word at a time.
REQ-024 mem_req, mem_addr and mem_we (0) SHALL be held until mem_ack.
REQ-025 On mem_ack in FETCH, lb_we=1 for that cycle with lb_wdata=mem_rdata.
REQ-026 In FETCH, the next word is requested the following cycle, giving 1 word/cycle at zero wait.
REQ-027 FETCH -> IDLE after the ack of word H_ACTIVE-1.
REQ-028 HOST SHALL drive one access from the host inputs.
REQ-029 On mem_ack in HOST: host_ack=1 for one cycle, host_rdata=mem_rdata; then return to IDLE.
REQ-030 A trigger during HOST SHALL be latched as pending and served immediately after the host access.
REQ-031 A trigger during FETCH SHALL pulse underrun one cycle after the trigger and abandon the old line.
REQ-032 On abandon, the in-flight handshake completes first (its lb write is suppressed); the new line then starts at word 0.
REQ-033 fetch_busy=1 exactly while in FETCH or with a fetch pending.
REQ-034 Address arithmetic SHALL be computed at AW bits, wrapping modulo 2^AW.
REQ-035 The host SHALL never be served while a fetch is pending or active.

Reset
REQ-036 While rst=1 on a clk edge: state=IDLE, pending cleared, word counter=0.
REQ-037 While rst=1: mem_req, host_ack, lb_we, underrun, fetch_busy=0; mem_addr, mem_wdata, lb_addr, lb_wdata, host_rdata=0.
REQ-038 Reset mid-handshake SHALL drop mem_req without waiting for mem_ack.

Structure
REQ-039 State encoding and bank/word-index widths SHALL live in shared package vga_pkg.
REQ-040 Address generation (line*H_ACTIVE+word) SHALL be sub-module vga_fetch_addr, registered, 1-cycle latency, with the arbiter pre-computing it.

Verification
REQ-041 Zero-wait memory, vdata=0, hdata=0 -> lines 1 words 0..639 at addr 640..1279, lb_addr 0x400..0x67F, fetch_busy low after 640 cycles.
REQ-042 vdata=524, hdata=0 -> fetch of line 0 at addr 0..639, bank 0.
REQ-043 host_req read at addr 0x12345 with trigger the same cycle -> fetch first; host_ack then follows 641+ cycles later with the correct data.
REQ-044 mem_ack withheld 200 cycles mid-fetch, next trigger arrives -> underrun pulse, no lb write for the stalled word, new line restarts at word 0.
REQ-045 rst asserted with mem_req high -> all outputs 0 next cycle; the following trigger fetches normally.
REQ-046 vdata=479..523 at hdata=0 -> no fetch, host requests served at 1 ack/cycle with zero-wait memory.
